// File: rtl/dtm_pkg.sv
// dtm_pkg: shared definitions for the JTAG DTM register block.
//   - DMI request op and response status encodings
//   - dtmcs field bit positions and a helper that assembles the capture word
//   - DMI handshake FSM state encoding
package dtm_pkg;

  // DMI request ops (dmi.op written by the debugger)
  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  // DMI response status (also the sticky error encoding)
  localparam logic [1:0] DMI_RSP_OK     = 2'd0;
  localparam logic [1:0] DMI_RSP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RSP_BUSY   = 2'd3;

  localparam int DTMCS_W             = 32;
  localparam int DTMCS_HARDRESET_BIT = 17;
  localparam int DTMCS_DMIRESET_BIT  = 16;
  localparam int DTMCS_IDLE_LSB      = 12;
  localparam int DTMCS_STAT_LSB      = 10;
  localparam int DTMCS_ABITS_LSB     = 4;
  localparam int DTMCS_VERSION_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } dmi_state_e;

  function automatic logic [DTMCS_W-1:0] dtmcs_word(input logic [2:0] idle,
                                                    input logic [1:0] stat,
                                                    input logic [5:0] abits,
                                                    input logic [3:0] version);
    logic [DTMCS_W-1:0] w;
    w = '0;
    w[DTMCS_IDLE_LSB    +: 3] = idle;
    w[DTMCS_STAT_LSB    +: 2] = stat;
    w[DTMCS_ABITS_LSB   +: 6] = abits;
    w[DTMCS_VERSION_LSB +: 4] = version;
    return w;
  endfunction

endpackage

// File: rtl/dtm_shift_reg.sv
// dtm_shift_reg: JTAG data register with parallel capture and LSB-first shift.
//   clk_i       - TCK
//   rst_i       - synchronous active-high reset (clears the register)
//   capture_i   - load cap_val_i
//   shift_i     - shift right one bit, tdi_i enters the MSB
//   tdi_i       - serial input
//   cap_val_i   - parallel capture value
//   q_o         - register contents (bit 0 feeds TDO)
module dtm_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             capture_i,
  input  logic             shift_i,
  input  logic             tdi_i,
  input  logic [WIDTH-1:0] cap_val_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else if (capture_i) begin
      sr_q <= cap_val_i;
    end else if (shift_i) begin
      sr_q <= {tdi_i, sr_q[WIDTH-1:1]};
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/dtm_dmi.sv
// dtm_dmi: JTAG DTM register block (dtmcs + dmi) in the TCK domain.
//   i_tck, i_rst                    - clock, synchronous active-high reset
//   i_capture/i_shift/i_update      - TAP strobes
//   i_sel_dtmcs/i_sel_dmi           - IR selects
//   i_tdi/o_tdo                     - serial data (o_tdo on falling edge)
//   o_req_*/i_req_ready             - DMI request toward the Debug Module
//   i_rsp_*                         - DMI response from the Debug Module
//   o_dmi_hardreset                 - one-cycle DM bus reset pulse
//
// state   | meaning
// IDLE    | no transaction outstanding
// REQ     | request presented, waiting for i_req_ready
// WAIT    | request accepted, waiting for i_rsp_valid
module dtm_dmi
  import dtm_pkg::*;
#(
  parameter int ABITS   = 7,
  parameter int IDLE    = 1,
  parameter int VERSION = 1
) (
  input  logic             i_tck,
  input  logic             i_rst,
  input  logic             i_capture,
  input  logic             i_shift,
  input  logic             i_update,
  input  logic             i_sel_dtmcs,
  input  logic             i_sel_dmi,
  input  logic             i_tdi,
  output logic             o_tdo,
  output logic             o_req_valid,
  input  logic             i_req_ready,
  output logic [ABITS-1:0] o_req_addr,
  output logic [31:0]      o_req_data,
  output logic [1:0]       o_req_op,
  input  logic             i_rsp_valid,
  input  logic [31:0]      i_rsp_data,
  input  logic [1:0]       i_rsp_op,
  output logic             o_dmi_hardreset
);

  localparam int DmiW = ABITS + 34;

  dmi_state_e       state_q, state_d;
  logic [1:0]       sticky_q, sticky_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       op_q, op_d;
  logic             hardreset_q;
  logic             tdo_q;

  logic [DTMCS_W-1:0] dtmcs_sr, dtmcs_cap;
  logic [DmiW-1:0]    dmi_sr, dmi_cap;
  logic [1:0]         dmi_cap_op;
  logic [ABITS-1:0]   upd_addr;
  logic [31:0]        upd_data;
  logic [1:0]         upd_op;

  logic cap_dtmcs, shift_dtmcs, upd_dtmcs;
  logic cap_dmi, shift_dmi, upd_dmi;
  logic busy, dmireset, hardreset;

  assign cap_dtmcs   = i_capture && i_sel_dtmcs;
  assign shift_dtmcs = i_shift   && i_sel_dtmcs;
  assign upd_dtmcs   = i_update  && i_sel_dtmcs;
  assign cap_dmi     = i_capture && i_sel_dmi;
  assign shift_dmi   = i_shift   && i_sel_dmi;
  assign upd_dmi     = i_update  && i_sel_dmi;

  assign busy      = (state_q != ST_IDLE);
  assign hardreset = upd_dtmcs && dtmcs_sr[DTMCS_HARDRESET_BIT];
  assign dmireset  = upd_dtmcs && dtmcs_sr[DTMCS_DMIRESET_BIT];

  assign dtmcs_cap = dtmcs_word(3'(IDLE), sticky_q, 6'(ABITS), 4'(VERSION));

  // A latched error takes precedence over the live busy indication.
  assign dmi_cap_op = (sticky_q != 2'd0) ? sticky_q :
                      busy               ? DMI_RSP_BUSY : DMI_RSP_OK;
  assign dmi_cap    = {addr_q, rdata_q, dmi_cap_op};

  assign {upd_addr, upd_data, upd_op} = dmi_sr;

  dtm_shift_reg #(.WIDTH(DTMCS_W)) u_dtmcs_sr (
    .clk_i     (i_tck),
    .rst_i     (i_rst),
    .capture_i (cap_dtmcs),
    .shift_i   (shift_dtmcs),
    .tdi_i     (i_tdi),
    .cap_val_i (dtmcs_cap),
    .q_o       (dtmcs_sr)
  );

  dtm_shift_reg #(.WIDTH(DmiW)) u_dmi_sr (
    .clk_i     (i_tck),
    .rst_i     (i_rst),
    .capture_i (cap_dmi),
    .shift_i   (shift_dmi),
    .tdi_i     (i_tdi),
    .cap_val_i (dmi_cap),
    .q_o       (dmi_sr)
  );

  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    op_d     = op_q;

    case (state_q)
      ST_REQ: begin
        if (i_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_rsp_valid) begin
          state_d = ST_IDLE;
          if (i_rsp_op == DMI_RSP_OK && op_q == DMI_OP_READ) rdata_d = i_rsp_data;
          if ((i_rsp_op == DMI_RSP_FAILED || i_rsp_op == DMI_RSP_BUSY) && sticky_q == 2'd0)
            sticky_d = i_rsp_op;
        end
      end
      default: ;
    endcase

    // Observing the dmi register mid-transaction means the debugger polled too fast.
    if (cap_dmi && busy && sticky_q == 2'd0) sticky_d = DMI_RSP_BUSY;

    if (upd_dmi && sticky_q == 2'd0) begin
      if (busy) begin
        sticky_d = DMI_RSP_BUSY;
      end else if (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE) begin
        addr_d  = upd_addr;
        wdata_d = upd_data;
        op_d    = upd_op;
        state_d = ST_REQ;
      end
    end

    if (dmireset || hardreset) sticky_d = 2'd0;

    // Hardreset abandons the transaction; a response on the same edge is dropped.
    if (hardreset) begin
      state_d = ST_IDLE;
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge i_tck) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sticky_q    <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      op_q        <= 2'd0;
      hardreset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sticky_q    <= sticky_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      op_q        <= op_d;
      hardreset_q <= hardreset;
    end
  end

  // TDO changes on the falling edge so it is stable for the TAP's rising-edge sample.
  always_ff @(negedge i_tck) begin
    if (i_rst) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= i_sel_dmi ? dmi_sr[0] : dtmcs_sr[0];
    end
  end

  logic unused_dtmcs;
  assign unused_dtmcs = ^{dtmcs_sr[DTMCS_W-1:DTMCS_HARDRESET_BIT+1],
                          dtmcs_sr[DTMCS_DMIRESET_BIT-1:0]};

  assign o_tdo           = tdo_q;
  assign o_req_valid     = (state_q == ST_REQ);
  assign o_req_addr      = addr_q;
  assign o_req_data      = wdata_q;
  assign o_req_op        = op_q;
  assign o_dmi_hardreset = hardreset_q;

endmodule

// File: tb/tb_dtm_dmi.sv
module tb_dtm_dmi;

  localparam int ABITS = 7;
  localparam int DMIW  = ABITS + 34;

  logic             i_tck = 1'b0;
  logic             i_rst;
  logic             i_capture, i_shift, i_update;
  logic             i_sel_dtmcs, i_sel_dmi;
  logic             i_tdi;
  logic             o_tdo;
  logic             o_req_valid;
  logic             i_req_ready;
  logic [ABITS-1:0] o_req_addr;
  logic [31:0]      o_req_data;
  logic [1:0]       o_req_op;
  logic             i_rsp_valid;
  logic [31:0]      i_rsp_data;
  logic [1:0]       i_rsp_op;
  logic             o_dmi_hardreset;

  typedef struct packed {
    logic [ABITS-1:0] addr;
    logic [31:0]      data;
    logic [1:0]       op;
  } req_t;

  req_t  exp_q[$];
  req_t  mon_got, mon_exp;
  int    compared   = 0;
  int    mismatched = 0;
  int    beats      = 0;
  logic [63:0] cap;
  logic        ok;

  dtm_dmi #(.ABITS(ABITS), .IDLE(1), .VERSION(1)) dut (
    .i_tck           (i_tck),
    .i_rst           (i_rst),
    .i_capture       (i_capture),
    .i_shift         (i_shift),
    .i_update        (i_update),
    .i_sel_dtmcs     (i_sel_dtmcs),
    .i_sel_dmi       (i_sel_dmi),
    .i_tdi           (i_tdi),
    .o_tdo           (o_tdo),
    .o_req_valid     (o_req_valid),
    .i_req_ready     (i_req_ready),
    .o_req_addr      (o_req_addr),
    .o_req_data      (o_req_data),
    .o_req_op        (o_req_op),
    .i_rsp_valid     (i_rsp_valid),
    .i_rsp_data      (i_rsp_data),
    .i_rsp_op        (i_rsp_op),
    .o_dmi_hardreset (o_dmi_hardreset)
  );

  always #5 i_tck = ~i_tck;

  // Request scoreboard: every accepted beat must match the oldest expected request.
  always @(negedge i_tck) begin
    if (!i_rst && o_req_valid && i_req_ready) begin
      mon_got = {o_req_addr, o_req_data, o_req_op};
      beats++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL req_beat: got %h, none expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          mismatched++;
          $display("FAIL req_beat: got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  function automatic logic [63:0] mk(input logic [ABITS-1:0] a, input logic [31:0] d,
                                     input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  // Entered and left at posedge+1: capture, shift width bits, update.
  task automatic scan(input logic sel_dmi, input int width, input logic [63:0] din,
                      output logic [63:0] dout);
    dout        = '0;
    i_sel_dmi   = sel_dmi;
    i_sel_dtmcs = !sel_dmi;
    i_capture   = 1'b1;
    @(posedge i_tck); #1;
    i_capture   = 1'b0;
    i_shift     = 1'b1;
    for (int i = 0; i < width; i++) begin
      i_tdi = din[i];
      @(negedge i_tck); #1;
      dout[i] = o_tdo;
      @(posedge i_tck); #1;
    end
    i_shift  = 1'b0;
    i_update = 1'b1;
    @(posedge i_tck); #1;
    i_update    = 1'b0;
    i_sel_dmi   = 1'b0;
    i_sel_dtmcs = 1'b0;
  endtask

  task automatic wait_accept(output logic acc);
    int n;
    n = 0;
    while (!(o_req_valid && i_req_ready) && n < 20) begin
      @(posedge i_tck); #1;
      n++;
    end
    acc = (n < 20);
    @(posedge i_tck); #1;
  endtask

  task automatic respond(input logic [1:0] op, input logic [31:0] d);
    i_rsp_valid = 1'b1;
    i_rsp_op    = op;
    i_rsp_data  = d;
    @(posedge i_tck); #1;
    i_rsp_valid = 1'b0;
    i_rsp_op    = 2'd0;
    i_rsp_data  = '0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_capture = 0; i_shift = 0; i_update = 0; i_sel_dtmcs = 0; i_sel_dmi = 0;
    i_tdi = 0; i_req_ready = 0; i_rsp_valid = 0; i_rsp_data = '0; i_rsp_op = 2'd0;
    repeat (3) @(posedge i_tck);
    @(negedge i_tck); #1;
    compared++;
    if ({o_req_valid, o_req_addr, o_req_data, o_req_op, o_dmi_hardreset, o_tdo} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b a=%h d=%h op=%h hr=%b tdo=%b, required all 0",
               o_req_valid, o_req_addr, o_req_data, o_req_op, o_dmi_hardreset, o_tdo);
    end
    @(posedge i_tck); #1;
    i_rst = 1'b0;
  endtask

  task automatic test_dtmcs();
    scan(1'b0, 32, 64'd0, cap);
    compared++;
    if (cap !== 64'h1071) begin
      mismatched++;
      $display("FAIL dtmcs_capture: got %h required %h", cap, 64'h1071);
    end
  endtask

  task automatic test_write();
    int b0;
    b0 = beats;
    i_req_ready = 1'b1;
    exp_q.push_back({7'h10, 32'hDEADBEEF, 2'd2});
    scan(1'b1, DMIW, mk(7'h10, 32'hDEADBEEF, 2'd2), cap);
    compared++;
    if (cap !== mk(7'h00, 32'h0, 2'd0)) begin
      mismatched++;
      $display("FAIL write_first_capture: got %h required %h", cap, mk(7'h00, 32'h0, 2'd0));
    end
    wait_accept(ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL write_accept: got timeout, required accept"); end
    compared++;
    if (o_req_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL write_valid_drop: got %b required 0", o_req_valid);
    end
    respond(2'd0, 32'h0BADF00D);
    scan(1'b1, DMIW, 64'd0, cap);
    compared++;
    if (cap !== mk(7'h10, 32'h0, 2'd0)) begin
      mismatched++;
      $display("FAIL write_capture: got %h required %h", cap, mk(7'h10, 32'h0, 2'd0));
    end
    compared++;
    if (beats - b0 !== 1) begin
      mismatched++;
      $display("FAIL write_beats: got %0d required 1", beats - b0);
    end
  endtask

  task automatic test_read();
    i_req_ready = 1'b1;
    exp_q.push_back({7'h04, 32'h0, 2'd1});
    scan(1'b1, DMIW, mk(7'h04, 32'h0, 2'd1), cap);
    wait_accept(ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL read_accept: got timeout, required accept"); end
    respond(2'd0, 32'h12345678);
    scan(1'b1, DMIW, 64'd0, cap);
    compared++;
    if (cap !== mk(7'h04, 32'h12345678, 2'd0)) begin
      mismatched++;
      $display("FAIL read_capture: got %h required %h", cap, mk(7'h04, 32'h12345678, 2'd0));
    end
  endtask

  task automatic test_busy();
    i_req_ready = 1'b0;
    scan(1'b1, DMIW, mk(7'h08, 32'h0, 2'd1), cap);
    compared++;
    if (o_req_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_valid: got %b required 1", o_req_valid);
    end
    scan(1'b1, DMIW, mk(7'h11, 32'hAAAA5555, 2'd2), cap);
    compared++;
    if (cap !== mk(7'h08, 32'h12345678, 2'd3)) begin
      mismatched++;
      $display("FAIL busy_capture: got %h required %h", cap, mk(7'h08, 32'h12345678, 2'd3));
    end
    compared++;
    if ({o_req_addr, o_req_data, o_req_op} !== {7'h08, 32'h0, 2'd1}) begin
      mismatched++;
      $display("FAIL busy_update_ignored: got %h/%h/%h required 08/00000000/1",
               o_req_addr, o_req_data, o_req_op);
    end
    scan(1'b0, 32, 64'd0, cap);
    compared++;
    if (cap !== 64'h1C71) begin
      mismatched++;
      $display("FAIL busy_dtmcs_sticky: got %h required %h", cap, 64'h1C71);
    end
    exp_q.push_back({7'h08, 32'h0, 2'd1});
    i_req_ready = 1'b1;
    wait_accept(ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL busy_accept: got timeout, required accept"); end
    respond(2'd0, 32'hCAFEF00D);
    scan(1'b0, 32, 64'h1 << 16, cap);
    scan(1'b1, DMIW, 64'd0, cap);
    compared++;
    if (cap !== mk(7'h08, 32'hCAFEF00D, 2'd0)) begin
      mismatched++;
      $display("FAIL busy_cleared_capture: got %h required %h", cap, mk(7'h08, 32'hCAFEF00D, 2'd0));
    end
  endtask

  task automatic test_error();
    i_req_ready = 1'b1;
    exp_q.push_back({7'h20, 32'h55, 2'd2});
    scan(1'b1, DMIW, mk(7'h20, 32'h55, 2'd2), cap);
    wait_accept(ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL error_accept: got timeout, required accept"); end
    respond(2'd2, 32'hFFFF);
    scan(1'b1, DMIW, 64'd0, cap);
    compared++;
    if (cap !== mk(7'h20, 32'hCAFEF00D, 2'd2)) begin
      mismatched++;
      $display("FAIL error_capture: got %h required %h", cap, mk(7'h20, 32'hCAFEF00D, 2'd2));
    end
    scan(1'b0, 32, 64'h1 << 16, cap);
    compared++;
    if (cap !== 64'h1871) begin
      mismatched++;
      $display("FAIL error_dtmcs: got %h required %h", cap, 64'h1871);
    end
    scan(1'b1, DMIW, 64'd0, cap);
    compared++;
    if (cap !== mk(7'h20, 32'hCAFEF00D, 2'd0)) begin
      mismatched++;
      $display("FAIL error_cleared: got %h required %h", cap, mk(7'h20, 32'hCAFEF00D, 2'd0));
    end
  endtask

  task automatic test_hardreset();
    // Hardreset while the request is still pending drops valid.
    i_req_ready = 1'b0;
    scan(1'b1, DMIW, mk(7'h28, 32'h1, 2'd2), cap);
    scan(1'b0, 32, 64'h1 << 17, cap);
    compared++;
    if ({o_dmi_hardreset, o_req_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL hr_req_pulse: got hr=%b valid=%b required hr=1 valid=0", o_dmi_hardreset, o_req_valid);
    end
    @(posedge i_tck); #1;
    compared++;
    if (o_dmi_hardreset !== 1'b0) begin
      mismatched++;
      $display("FAIL hr_req_pulse_end: got %b required 0", o_dmi_hardreset);
    end
    // Hardreset while waiting for the response; the late response is ignored.
    i_req_ready = 1'b1;
    exp_q.push_back({7'h30, 32'h77, 2'd2});
    scan(1'b1, DMIW, mk(7'h30, 32'h77, 2'd2), cap);
    compared++;
    if (cap !== mk(7'h28, 32'hCAFEF00D, 2'd0)) begin
      mismatched++;
      $display("FAIL hr_idle_capture: got %h required %h", cap, mk(7'h28, 32'hCAFEF00D, 2'd0));
    end
    wait_accept(ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL hr_accept: got timeout, required accept"); end
    i_req_ready = 1'b0;
    scan(1'b0, 32, 64'h3 << 16, cap);
    compared++;
    if (o_dmi_hardreset !== 1'b1) begin
      mismatched++;
      $display("FAIL hr_wait_pulse: got %b required 1", o_dmi_hardreset);
    end
    respond(2'd2, 32'h00000BAD);
    compared++;
    if (o_dmi_hardreset !== 1'b0) begin
      mismatched++;
      $display("FAIL hr_wait_pulse_end: got %b required 0", o_dmi_hardreset);
    end
    scan(1'b1, DMIW, 64'd0, cap);
    compared++;
    if (cap !== mk(7'h30, 32'hCAFEF00D, 2'd0)) begin
      mismatched++;
      $display("FAIL hr_late_rsp_ignored: got %h required %h", cap, mk(7'h30, 32'hCAFEF00D, 2'd0));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]      prev;
    logic [31:0]      d;
    logic [ABITS-1:0] a;
    prev = mk(7'h30, 32'hCAFEF00D, 2'd0);
    i_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 7'(8'h40 + i);
      d = $urandom;
      exp_q.push_back({a, 32'h0, 2'd1});
      scan(1'b1, DMIW, mk(a, 32'h0, 2'd1), cap);
      compared++;
      if (cap !== prev) begin
        mismatched++;
        $display("FAIL b2b_capture_%0d: got %h required %h", i, cap, prev);
      end
      wait_accept(ok);
      compared++;
      if (ok !== 1'b1) begin mismatched++; $display("FAIL b2b_accept_%0d: got timeout, required accept", i); end
      respond(2'd0, d);
      prev = mk(a, d, 2'd0);
    end
    scan(1'b1, DMIW, 64'd0, cap);
    compared++;
    if (cap !== prev) begin
      mismatched++;
      $display("FAIL b2b_final: got %h required %h", cap, prev);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dtmcs();
    test_write();
    test_read();
    test_busy();
    test_error();
    test_hardreset();
    test_back_to_back();
    repeat (2) @(posedge i_tck);
    #1;
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dtm_dmi.md
# dtm_dmi

JTAG Debug Transport Module register block combining the `dtmcs` and `dmi` data registers in the TCK domain. It is the parametrised successor of the fixed-width dtmcs register: configurable DMI address width and advertised idle count, a full DMI request/response handshake toward the Debug Module, busy detection and sticky error tracking. It sits between the TAP controller (IR decode, capture/shift/update strobes) and the Debug Module bus interface.

## Interface
- `ABITS`, 7, DMI address width (1..32); reported in `dtmcs.abits`
- `IDLE`, 1, run-test-idle cycles hint (0..7); reported in `dtmcs.idle`
- `VERSION`, 1, `dtmcs.version` field (4 bits)

- `i_tck` in 1 – sole clock; all state on rising edge except `o_tdo`
- `i_rst` in 1 – synchronous, active-high reset
- `i_capture`, `i_shift`, `i_update` in 1 each – TAP state strobes, mutually exclusive
- `i_sel_dtmcs`, `i_sel_dmi` in 1 each – IR selects; at most one high
- `i_tdi` in 1 – serial in
- `o_tdo` out 1 – serial out, bit 0 of selected shift register
- `o_req_valid` out 1, `i_req_ready` in 1 – DMI request handshake
- `o_req_addr` out ABITS, `o_req_data` out 32, `o_req_op` out 2 (1=read, 2=write)
- `i_rsp_valid` in 1, `i_rsp_data` in 32, `i_rsp_op` in 2 (0=ok, 2=failed, 3=busy)
- `o_dmi_hardreset` out 1 – one-cycle pulse to reset the DM bus side

## Operation
- Two shift registers: dtmcs (32 bits), dmi (ABITS+34 bits: `{addr, data, op}`, op in [1:0]). Only the selected one captures/shifts/updates; the other holds.
- Shift: register shifts right one bit per strobe; `i_tdi` enters MSB.
- dtmcs capture: [31:18]=0, [17:16]=0, [15]=0, [14:12]=IDLE, [11:10]=sticky, [9:4]=ABITS, [3:0]=VERSION.
- dtmcs update: bit16 (dmireset) clears sticky. Bit17 (dmihardreset) clears sticky, forces FSM to IDLE (abandoning any transaction, dropping `o_req_valid`) and pulses `o_dmi_hardreset`. Both set: hardreset behaviour.
- dmi capture: addr = last issued address, data = last read data, op = sticky if non-zero; else 3 if FSM not IDLE; else 0. Capturing while busy also sets sticky=3.
- dmi update: ignored if sticky≠0. If FSM not IDLE: sticky←3, no request. Else op 1 or 2: latch addr/data/op, FSM→REQ. Op 0 or 3: no action.
- FSM: IDLE → REQ on accepted update; REQ → WAIT on `o_req_valid && i_req_ready`; WAIT → IDLE on `i_rsp_valid`. `i_rsp_valid` outside WAIT ignored.
- Response: read with `i_rsp_op`=0 loads data-last from `i_rsp_data`; write responses leave it. `i_rsp_op` 2 or 3 → sticky←`i_rsp_op` (only when sticky is 0); data-last unchanged.
- Sticky is 2 bits; once non-zero it holds until dmireset/dmihardreset/`i_rst`.

## Timing
- Reset values: `o_req_valid`=0, `o_req_addr`=0, `o_req_data`=0, `o_req_op`=0, `o_dmi_hardreset`=0, `o_tdo`=0; sticky=0, FSM=IDLE, data-last=0, addr-last=0.
- `o_tdo` updates on the falling edge of `i_tck` from bit 0 of the selected register (dtmcs when neither selected); `i_rst` high at a falling edge forces 0.
- Update on edge N → `o_req_valid` high after edge N; request fields stable while valid is high.
- `o_dmi_hardreset` high exactly one cycle after the update edge.
- Response on edge M → FSM IDLE and data-last valid after edge M; capture on edge M+1 returns new data.
- Response and dmihardreset on the same edge: hardreset wins, response discarded.

## Structure
- Package `dtm_pkg`: DMI op encodings (NOP/READ/WRITE, OK/FAILED/BUSY), dtmcs field bit positions, FSM state enum (IDLE, REQ, WAIT).
- Sub-module `dtm_shift_reg` (parameter WIDTH): capture/shift register, instantiated for dtmcs and dmi.

## Test plan
- Reset, select dtmcs, capture with ABITS=7, IDLE=1, VERSION=1 → shifted-out word 0x00001071.
- dmi write addr 0x10 data 0xDEADBEEF, ready held 1, response op 0 → one request beat with op=2; next capture op=0.
- dmi read addr 0x04, response data 0x12345678 op 0 → next capture data=0x12345678, addr=0x04, op=0.
- Update with `i_req_ready` stuck 0, then capture → op=3, sticky=3; a further update issues no request; dtmcs capture shows [11:10]=3.
- Response op 2 → sticky=2; dtmcs write bit16 → sticky=0, next dmi capture op=0.
- dmihardreset while in WAIT → `o_dmi_hardreset` single pulse, `o_req_valid`=0, FSM IDLE, late `i_rsp_valid` ignored.
